// File: rtl/led_cube_scan_driver.sv
// Scan driver for an 8x8x8 LED cube: double-buffered 64-byte frame, layer/row multiplexing.
// Optional macro LED_CUBE_DIM_EN adds a 4-bit brightness input that shortens the lit part of ON.
module led_cube_scan_driver #(
  parameter int unsigned DWELL_CYCLES = 6250,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned PULSE_CYC    = 2,
  parameter int unsigned BLANK_CYC    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       frame_swap,
`ifdef LED_CUBE_DIM_EN
  input  logic [3:0] brightness,
`endif
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] layers,
  output logic [7:0] latches,
  output logic [7:0] data
);

  localparam int unsigned MAX_A   = (DWELL_CYCLES > SETUP_CYC) ? DWELL_CYCLES : SETUP_CYC;
  localparam int unsigned MAX_B   = (PULSE_CYC > BLANK_CYC) ? PULSE_CYC : BLANK_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_BLANK,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_ON
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    layer, layer_n;
  logic [2:0]    row, row_n;
  logic          boot;
  logic          front_sel, front_sel_n;
  logic          swap_pending, swap_pending_n;
  logic          frame_entry;
  logic          lit_n;
  logic          swap_ack_n;
  logic [7:0]    layers_n, latches_n;
  logic [6:0]    rd_addr;
  logic          rd_en;

  // Two banks of 64 rows; bank index is the MSB of the address.
  logic [7:0] mem [128];

`ifdef LED_CUBE_DIM_EN
  localparam int unsigned LW = CW + 1;
  logic [LW-1:0] on_limit, on_limit_n;
`endif

  // Writes always target the bank that is not being displayed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~front_sel, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      layer        <= '0;
      row          <= '0;
      boot         <= 1'b1;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      frame_start  <= 1'b0;
      layers       <= '0;
      latches      <= '0;
      data         <= '0;
`ifdef LED_CUBE_DIM_EN
      on_limit     <= '0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      layer        <= layer_n;
      row          <= row_n;
      boot         <= 1'b0;
      front_sel    <= front_sel_n;
      swap_pending <= swap_pending_n;
      swap_ack     <= swap_ack_n;
      frame_start  <= frame_entry;
      layers       <= layers_n;
      latches      <= latches_n;
      if (rd_en) data <= mem[rd_addr];
`ifdef LED_CUBE_DIM_EN
      on_limit     <= on_limit_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt + CW'(1);
    layer_n        = layer;
    row_n          = row;
    frame_entry    = 1'b0;
    front_sel_n    = front_sel;
    swap_pending_n = swap_pending | frame_swap;
    swap_ack_n     = 1'b0;
    lit_n          = 1'b1;

    // The first edge after reset enters layer 0 BLANK as a fresh frame.
    if (boot) begin
      state_n     = ST_BLANK;
      cnt_n       = '0;
      layer_n     = '0;
      row_n       = '0;
      frame_entry = 1'b1;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = ST_SETUP;
            cnt_n   = '0;
            row_n   = '0;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state_n = ST_PULSE;
            cnt_n   = '0;
          end
        end
        ST_PULSE: begin
          if (cnt == PULSE_LAST) begin
            state_n = ST_HOLD;
            cnt_n   = '0;
          end
        end
        ST_HOLD: begin
          cnt_n = '0;
          if (row == 3'd7) begin
            state_n = ST_ON;
          end else begin
            state_n = ST_SETUP;
            row_n   = row + 3'd1;
          end
        end
        ST_ON: begin
          if (cnt == DWELL_LAST) begin
            state_n     = ST_BLANK;
            cnt_n       = '0;
            layer_n     = layer + 3'd1;
            frame_entry = (layer == 3'd7);
          end
        end
        default: begin
          state_n = ST_BLANK;
          cnt_n   = '0;
        end
      endcase
    end

    // Bank swap is only allowed on the frame boundary so a frame is never torn.
    if (frame_entry && (swap_pending || frame_swap)) begin
      front_sel_n    = ~front_sel;
      swap_pending_n = 1'b0;
      swap_ack_n     = 1'b1;
    end

`ifdef LED_CUBE_DIM_EN
    on_limit_n = on_limit;
    if (state == ST_HOLD && state_n == ST_ON)
      on_limit_n = LW'(((32'(brightness) + 32'd1) * DWELL_CYCLES) / 32'd16);
    lit_n = ({1'b0, cnt_n} < on_limit_n);
`endif

    layers_n  = (state_n == ST_ON && lit_n) ? (8'b1 << layer_n) : 8'h00;
    latches_n = (state_n == ST_PULSE) ? (8'b1 << row_n) : 8'h00;
    rd_en     = (state_n == ST_SETUP);
    rd_addr   = {front_sel_n, layer_n, row_n};
  end

endmodule
